vector_loader: RTL and testbench
================================

// Module: vector_loader
// PURPOSE
//   Loads the 8-bit input and weight vectors into the lookup memories that
//   selection logic later reads by index.
//   Accepts a stream of (input, weight) byte pairs over a valid/ready handshake.
//   Writes each pair to an auto-incrementing address on a registered write port.
//   Pulses done when the programmed number of pairs has been written.
// PARAMETERS
//   N     16   address width; memories hold 2**N entries
// PORTS
//   clk       in   1    system clock, all logic on rising edge
//   rst_n     in   1    asynchronous active-low reset
//   start     in   1    begin a load; sampled only in IDLE
//   len       in   N+1  number of pairs to load; sampled with start
//   s_valid   in   1    stream pair valid
//   s_ready   out  1    loader can accept a pair
//   s_in      in   8    input-vector byte
//   s_w       in   8    weight-vector byte
//   mem_we    out  1    write strobe to both memories
//   mem_addr  out  N    write address
//   mem_in    out  8    data for input-vector memory
//   mem_w     out  8    data for weight-vector memory
//   busy      out  1    high in LOAD and DONE states
//   done      out  1    one-cycle pulse when load completes
//   count     out  N+1  pairs written so far in current/last load
// BEHAVIOUR
//   Reset (rst_n=0, async)
//   - state=IDLE.
//   - All outputs 0: s_ready, mem_we, mem_addr, mem_in, mem_w, busy, done, count.
//   - Partially loaded memory contents are not cleared.
//   States: IDLE -> LOAD -> DONE -> IDLE.
//   IDLE
//   - s_ready=0.
//   - On start=1: latch len (saturated to 2**N if larger); count<=0.
//   - len=0: go to DONE; otherwise go to LOAD.
//   LOAD
//   - s_ready=1, combinational from state.
//   - A handshake (s_valid & s_ready) registers one write. Next cycle:
//     mem_we=1, mem_addr=count[N-1:0], mem_in=s_in, mem_w=s_w; count<=count+1.
//   - mem_we is 0 in every cycle not following a handshake.
//   - Addresses run 0..len-1 in order; they never wrap within one load.
//   - When the handshake carries pair number len (count==len-1), go to DONE.
//     s_ready is 0 from the next cycle on.
//   - Gaps in s_valid are allowed; state and count hold.
//   DONE
//   - One cycle: done=1, busy=1, s_ready=0. Then return to IDLE.
//   - The last pair's mem_we falls in the same cycle as done=1.
//   start outside IDLE
//   - Ignored, including start held high through DONE.
//   - A new load needs start sampled in IDLE.
//   Latency and hold rules
//   - Latency from handshake to memory write: exactly 1 cycle.
//   - count holds its final value after DONE until the next start.
//   - mem_addr, mem_in and mem_w hold their last value when mem_we=0.
//   Reset mid-load
//   - Aborts immediately; no further writes.
//   - No done pulse for the aborted load.
// TESTING
//   1. Reset with rst_n=0 mid-clock -> all outputs 0 asynchronously, state IDLE.
//   2. start, len=4; s_valid held 1, pairs (1,10),(2,20),(3,30),(4,40) ->
//      mem_we on 4 consecutive cycles at addr 0..3 with matching data;
//      done pulses with the addr-3 write; count=4.
//   3. len=3 with s_valid toggling 1,0,0,1,0,1 -> exactly 3 writes at addr 0,1,2;
//      no write in gap cycles; done once.
//   4. start, len=0 -> done on the 2nd cycle after start; mem_we never asserted;
//      s_ready stays 0.
//   5. start pulsed again during LOAD and held through DONE -> no restart;
//      count unaffected; a new start in IDLE begins a fresh load at addr 0.
//   6. rst_n=0 after 2 of 5 pairs -> no further mem_we, no done;
//      subsequent start, len=1 writes addr 0 and pulses done.

Source files
------------

// File: rtl/vector_loader.sv
// vector_loader: streams (input, weight) byte pairs into two lookup memories
// at auto-incrementing addresses, then pulses done after the requested count.
module vector_loader #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N:0]   len,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [7:0]   s_in,
    input  logic [7:0]   s_w,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [7:0]   mem_in,
    output logic [7:0]   mem_w,
    output logic         busy,
    output logic         done,
    output logic [N:0]   count
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    // Registered write port presented to both memories.
    typedef struct packed {
        logic         we;
        logic [N-1:0] addr;
        logic [7:0]   din;
        logic [7:0]   dw;
    } wr_t;

    // Largest load that fits the memories without wrapping the address.
    localparam logic [N:0] MAX_LEN = {1'b1, {N{1'b0}}};

    state_t     state, state_nxt;
    wr_t        wr_q;
    logic [N:0] len_q;
    logic [N:0] len_sat;
    logic       in_load;
    logic       hs;
    logic       last;

    assign in_load = (state == LOAD);
    assign hs      = s_valid & in_load;
    assign last    = hs && (count == len_q - 1'b1);
    assign len_sat = (len > MAX_LEN) ? MAX_LEN : len;

    assign s_ready  = in_load;
    assign mem_we   = wr_q.we;
    assign mem_addr = wr_q.addr;
    assign mem_in   = wr_q.din;
    assign mem_w    = wr_q.dw;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status decode; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len == '0) ? DONE : LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Length latch, pair counter and the one-cycle-delayed write port.
    // Address and data hold between writes; only the strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            count <= '0;
            wr_q  <= '0;
        end else begin
            wr_q.we <= hs;
            if (state == IDLE && start) begin
                len_q <= len_sat;
                count <= '0;
            end
            if (hs) begin
                wr_q.addr <= count[N-1:0];
                wr_q.din  <= s_in;
                wr_q.dw   <= s_w;
                count     <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_loader.sv
// tb_vector_loader: directed checks of the pair loader (small N so the
// length-saturation boundary is reachable in a few cycles).
module tb_vector_loader;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N:0]   len;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_in;
    logic [7:0]   s_w;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [7:0]   mem_in;
    logic [7:0]   mem_w;
    logic         busy;
    logic         done;
    logic [N:0]   count;

    vector_loader #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .s_valid(s_valid), .s_ready(s_ready), .s_in(s_in), .s_w(s_w),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_in(mem_in), .mem_w(mem_w),
        .busy(busy), .done(done), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled on the falling edge.
    logic [N-1:0] wa_q[$];
    logic [7:0]   wi_q[$];
    logic [7:0]   ww_q[$];
    int           wc_q[$];
    int           done_cnt;
    logic         done_we;
    logic [N-1:0] done_addr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we === 1'b1) begin
                wa_q.push_back(mem_addr);
                wi_q.push_back(mem_in);
                ww_q.push_back(mem_w);
                wc_q.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt  = done_cnt + 1;
                done_we   = mem_we;
                done_addr = mem_addr;
            end
        end
    end

    task automatic clear_mon();
        wa_q.delete(); wi_q.delete(); ww_q.delete(); wc_q.delete();
        done_cnt = 0; done_we = 1'b0; done_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_in = '0; s_w = '0;
        clear_mon();
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({s_ready, mem_we, busy, done} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", {s_ready, mem_we, busy, done}); end
        n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0h want 0", mem_addr); end
        n_tests++; if ({mem_in, mem_w} !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", {mem_in, mem_w}); end
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if ({s_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_idle got %b want 00", {s_ready, busy}); end
    endtask

    task automatic test_stream();
        logic [7:0] ein [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        logic [7:0] ew  [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        int hc[4];
        clear_mon();
        start = 1'b1; len = 5'd4;
        tick();
        start = 1'b0;
        n_tests++; if ({s_ready, busy} !== 2'b11) begin n_fail++; $display("FAIL stream_load got %b want 11", {s_ready, busy}); end
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_in = ein[i]; s_w = ew[i]; hc[i] = cyc;
            tick();
        end
        s_valid = 1'b0;
        n_tests++; if ({done, mem_we, s_ready} !== 3'b110) begin n_fail++; $display("FAIL stream_done_cycle got %b want 110", {done, mem_we, s_ready}); end
        tick(); tick();
        n_tests++; if (wa_q.size() !== 4) begin n_fail++; $display("FAIL stream_nwrites got %0d want 4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            n_tests++; if ({wa_q[i], wi_q[i], ww_q[i]} !== {4'(i), ein[i], ew[i]}) begin n_fail++; $display("FAIL stream_write%0d got %h want %h", i, {wa_q[i], wi_q[i], ww_q[i]}, {4'(i), ein[i], ew[i]}); end
            n_tests++; if (wc_q[i] !== hc[i] + 1) begin n_fail++; $display("FAIL stream_latency%0d got cyc %0d want %0d", i, wc_q[i], hc[i] + 1); end
        end
        n_tests++; if ({done_cnt, done_we, done_addr} !== {32'd1, 1'b1, 4'd3}) begin n_fail++; $display("FAIL stream_done got cnt %0d we %b addr %0d want 1 1 3", done_cnt, done_we, done_addr); end
        n_tests++; if ({count, busy} !== {5'd4, 1'b0}) begin n_fail++; $display("FAIL stream_count got %0d busy %b want 4 0", count, busy); end
    endtask

    task automatic test_gaps();
        int         vpat [6] = '{1, 0, 0, 1, 0, 1};
        logic [7:0] ein  [3] = '{8'h30, 8'h33, 8'h35};
        logic [7:0] ew   [3] = '{8'hC0, 8'hC3, 8'hC5};
        int hc[$];
        clear_mon();
        start = 1'b1; len = 5'd3;
        tick();
        start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            s_valid = (vpat[j] != 0); s_in = 8'h30 + 8'(j); s_w = 8'hC0 + 8'(j);
            if (vpat[j] != 0) hc.push_back(cyc);
            tick();
        end
        s_valid = 1'b0;
        tick(); tick();
        n_tests++; if (wa_q.size() !== 3) begin n_fail++; $display("FAIL gaps_nwrites got %0d want 3", wa_q.size()); end
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            n_tests++; if ({wa_q[i], wi_q[i], ww_q[i]} !== {4'(i), ein[i], ew[i]}) begin n_fail++; $display("FAIL gaps_write%0d got %h want %h", i, {wa_q[i], wi_q[i], ww_q[i]}, {4'(i), ein[i], ew[i]}); end
            n_tests++; if (wc_q[i] !== hc[i] + 1) begin n_fail++; $display("FAIL gaps_latency%0d got cyc %0d want %0d", i, wc_q[i], hc[i] + 1); end
        end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL gaps_done got %0d want 1", done_cnt); end
        n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL gaps_count got %0d want 3", count); end
    endtask

    task automatic test_len_zero();
        clear_mon();
        start = 1'b1; len = 5'd0; s_valid = 1'b1;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_early_done got %b want 0", done); end
        tick();
        start = 1'b0;
        n_tests++; if ({done, busy, s_ready} !== 3'b110) begin n_fail++; $display("FAIL zero_done_cycle got %b want 110", {done, busy, s_ready}); end
        tick();
        n_tests++; if ({done, busy, s_ready} !== 3'b000) begin n_fail++; $display("FAIL zero_after got %b want 000", {done, busy, s_ready}); end
        s_valid = 1'b0;
        tick();
        n_tests++; if ({wa_q.size(), done_cnt, count} !== {32'd0, 32'd1, 5'd0}) begin n_fail++; $display("FAIL zero_summary got writes %0d done %0d count %0d want 0 1 0", wa_q.size(), done_cnt, count); end
    endtask

    task automatic test_no_restart();
        clear_mon();
        start = 1'b1; len = 5'd3;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_in = 8'h11; s_w = 8'h21;
        tick();
        start = 1'b1; len = 5'd7;
        s_in = 8'h12; s_w = 8'h22;
        tick();
        s_in = 8'h13; s_w = 8'h23;
        tick();
        s_valid = 1'b0;
        n_tests++; if ({done, count} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL norestart_done got done %b count %0d want 1 3", done, count); end
        tick();
        start = 1'b0;
        n_tests++; if ({busy, count} !== {1'b0, 5'd3}) begin n_fail++; $display("FAIL norestart_idle got busy %b count %0d want 0 3", busy, count); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL norestart_stay got busy %b want 0", busy); end
        n_tests++; if ({wa_q.size(), done_cnt} !== {32'd3, 32'd1}) begin n_fail++; $display("FAIL norestart_counts got writes %0d done %0d want 3 1", wa_q.size(), done_cnt); end
        clear_mon();
        start = 1'b1; len = 5'd2;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_in = 8'h44; s_w = 8'h55;
        tick();
        s_in = 8'h45; s_w = 8'h56;
        tick();
        s_valid = 1'b0;
        tick(); tick();
        n_tests++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL fresh_nwrites got %0d want 2", wa_q.size()); end
        if (wa_q.size() == 2) begin
            n_tests++; if ({wa_q[0], wi_q[0], ww_q[0], wa_q[1], wi_q[1], ww_q[1]} !== {4'd0, 8'h44, 8'h55, 4'd1, 8'h45, 8'h56}) begin n_fail++; $display("FAIL fresh_writes got %h want 0445514556", {wa_q[0], wi_q[0], ww_q[0], wa_q[1], wi_q[1], ww_q[1]}); end
        end
        n_tests++; if ({count, done_cnt} !== {5'd2, 32'd1}) begin n_fail++; $display("FAIL fresh_count got count %0d done %0d want 2 1", count, done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        start = 1'b1; len = 5'd5;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_in = 8'h61; s_w = 8'h71;
        tick();
        s_in = 8'h62; s_w = 8'h72;
        tick();
        s_valid = 1'b0;
        #6 rst_n = 1'b0;
        s_valid = 1'b1; s_in = 8'h63; s_w = 8'h73;
        #1;
        n_tests++; if ({s_ready, mem_we, busy, done, count, mem_addr} !== '0) begin n_fail++; $display("FAIL midreset_async got rdy %b we %b busy %b done %b count %0d addr %0d want all 0", s_ready, mem_we, busy, done, count, mem_addr); end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        s_valid = 1'b0;
        tick();
        n_tests++; if ({wa_q.size(), done_cnt} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL midreset_abort got writes %0d done %0d want 2 0", wa_q.size(), done_cnt); end
        clear_mon();
        start = 1'b1; len = 5'd1;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_in = 8'hAA; s_w = 8'hBB;
        tick();
        s_valid = 1'b0;
        tick(); tick();
        n_tests++; if (wa_q.size() !== 1) begin n_fail++; $display("FAIL afterreset_nwrites got %0d want 1", wa_q.size()); end
        if (wa_q.size() == 1) begin
            n_tests++; if ({wa_q[0], wi_q[0], ww_q[0]} !== {4'd0, 8'hAA, 8'hBB}) begin n_fail++; $display("FAIL afterreset_write got %h want 0aabb", {wa_q[0], wi_q[0], ww_q[0]}); end
        end
        n_tests++; if ({done_cnt, done_we, count} !== {32'd1, 1'b1, 5'd1}) begin n_fail++; $display("FAIL afterreset_done got done %0d we %b count %0d want 1 1 1", done_cnt, done_we, count); end
    endtask

    // len above 2**N must load exactly 2**N pairs, addresses 0..15 with no wrap.
    task automatic test_saturate();
        clear_mon();
        start = 1'b1; len = 5'd31;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_in = 8'(i); s_w = 8'hF0 ^ 8'(i);
            tick();
        end
        s_valid = 1'b0;
        n_tests++; if ({done, mem_we, mem_addr} !== {1'b1, 1'b1, 4'd15}) begin n_fail++; $display("FAIL sat_done_cycle got done %b we %b addr %0d want 1 1 15", done, mem_we, mem_addr); end
        tick(); tick();
        n_tests++; if (wa_q.size() !== 16) begin n_fail++; $display("FAIL sat_nwrites got %0d want 16", wa_q.size()); end
        for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
            n_tests++; if ({wa_q[i], wi_q[i], ww_q[i]} !== {4'(i), 8'(i), 8'hF0 ^ 8'(i)}) begin n_fail++; $display("FAIL sat_write%0d got %h want %h", i, {wa_q[i], wi_q[i], ww_q[i]}, {4'(i), 8'(i), 8'hF0 ^ 8'(i)}); end
        end
        n_tests++; if ({count, done_cnt} !== {5'd16, 32'd1}) begin n_fail++; $display("FAIL sat_count got count %0d done %0d want 16 1", count, done_cnt); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_len_zero();
        test_no_restart();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
